// File: rtl/sm_status_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sm_status_uart_tx                                          |
// | Description : Sends one fixed ASCII status message "SI-D-C-#" per        |
// |               tx_start request as 8N1 UART, LSB first, with a 4-phase    |
// |               tx_start/tx_done handshake.                                |
// |               Optional macro SM_STATUS_TX_CRLF_EN appends CR LF.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sm_status_uart_tx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [1:0] si_no,
    input  logic [1:0] color,
    output logic       tx,
    output logic       tx_done,
    output logic       busy
);

    localparam int c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_baud_w-1:0] c_baud_one  = c_baud_w'(1);

`ifdef SM_STATUS_TX_CRLF_EN
    localparam logic [3:0] c_last_byte = 4'd9;
`else
    localparam logic [3:0] c_last_byte = 4'd7;
`endif

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_stop  = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    logic [2:0]          r_state;
    logic [c_baud_w-1:0] r_baud_cnt;
    logic [2:0]          r_bit_idx;
    logic [3:0]          r_byte_idx;
    logic [1:0]          r_si_no;
    logic [1:0]          r_color;
    logic                r_tx;
    logic                r_tx_done;
    logic                r_busy;
    logic [7:0]          w_byte;
    logic                w_bit_end;

    assign w_bit_end = (r_baud_cnt == c_baud_last);

    // Message byte currently on the line, built from the values latched at accept
    always_comb begin
        w_byte = 8'h23;
        case (r_byte_idx)
            4'd0: w_byte = 8'h53;                     // 'S'
            4'd1: w_byte = 8'h49;                     // 'I'
            4'd2: w_byte = 8'h2D;                     // '-'
            4'd3: w_byte = 8'h31 + {6'd0, r_si_no};   // '1'..'4'
            4'd4: w_byte = 8'h2D;
            4'd5: begin
                case (r_color)
                    2'd0:    w_byte = 8'h4E;          // 'N'
                    2'd1:    w_byte = 8'h52;          // 'R'
                    2'd2:    w_byte = 8'h47;          // 'G'
                    default: w_byte = 8'h42;          // 'B'
                endcase
            end
            4'd6: w_byte = 8'h2D;
            4'd7: w_byte = 8'h23;                     // '#'
`ifdef SM_STATUS_TX_CRLF_EN
            4'd8: w_byte = 8'h0D;
            4'd9: w_byte = 8'h0A;
`endif
            default: w_byte = 8'h23;
        endcase
    end

    // Transmit FSM; tx is registered and updated on each bit boundary so the
    // line level for the next bit is presented on the edge that ends the last one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_si_no    <= '0;
            r_color    <= '0;
            r_tx       <= 1'b1;
            r_tx_done  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (tx_start) begin
                        r_state    <= c_st_start;
                        r_si_no    <= si_no;
                        r_color    <= color;
                        r_byte_idx <= '0;
                        r_bit_idx  <= '0;
                        r_baud_cnt <= '0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                c_st_start: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_tx       <= w_byte[0];
                        r_state    <= c_st_data;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_baud_one;
                    end
                end
                c_st_data: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= c_st_stop;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= w_byte[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_baud_one;
                    end
                end
                c_st_stop: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_byte_idx == c_last_byte) begin
                            r_tx_done <= 1'b1;
                            r_state   <= c_st_done;
                        end else begin
                            // next start bit follows the stop bit with no idle gap
                            r_byte_idx <= r_byte_idx + 4'd1;
                            r_tx       <= 1'b0;
                            r_state    <= c_st_start;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_baud_one;
                    end
                end
                c_st_done: begin
                    // waiting for the requester to drop tx_start closes the handshake
                    if (!tx_start) begin
                        r_tx_done <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= c_st_idle;
                    end
                end
                default: begin
                    r_state   <= c_st_idle;
                    r_tx      <= 1'b1;
                    r_tx_done <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign tx      = r_tx;
    assign tx_done = r_tx_done;
    assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sm_status_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sm_status_uart_tx                                       |
// | Description : Self-checking bench for sm_status_uart_tx: vector table of |
// |               si_no/color requests, UART receiver with byte scoreboard,  |
// |               handshake, input-stability and mid-frame reset sequences.  |
// |               Honours SM_STATUS_TX_CRLF_EN.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sm_status_uart_tx;

    localparam int c_cpb = 10;
`ifdef SM_STATUS_TX_CRLF_EN
    localparam int c_nbytes = 10;
`else
    localparam int c_nbytes = 8;
`endif
    localparam int c_frame = c_nbytes * 10 * c_cpb;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [1:0] si_no;
    logic [1:0] color;
    logic       tx;
    logic       tx_done;
    logic       busy;

    sm_status_uart_tx #(
        .CLK_FREQ (1000),
        .BAUD     (100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .si_no    (si_no),
        .color    (color),
        .tx       (tx),
        .tx_done  (tx_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int         n_pass  = 0;
    int         n_total = 0;
    int         cyc     = 0;
    logic [7:0] sb[$];
    bit         mon_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // UART receiver: samples mid-bit on negedges and scores each byte
    initial begin : monitor
        logic       prev;
        logic [7:0] b;
        logic [7:0] e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev = 1'b1;
            end else if (prev && !tx) begin
                repeat (4) @(negedge clk);
                check("start_bit", 32'(tx), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (c_cpb) @(negedge clk);
                    b[i] = tx;
                end
                repeat (c_cpb) @(negedge clk);
                check("stop_bit", 32'(tx), 32'd1);
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL rx_byte: got 0x%0h expected no byte", b);
                end else begin
                    e = sb.pop_front();
                    check("rx_byte", 32'(b), 32'(e));
                end
                prev = tx;
            end else begin
                prev = tx;
            end
        end
    end

    typedef struct {
        logic [1:0] si;
        logic [1:0] co;
        logic [7:0] d;
        logic [7:0] c;
    } vec_t;

    vec_t vecs[6];

    task automatic push_frame(input logic [7:0] d, input logic [7:0] c);
        sb.push_back(8'h53);
        sb.push_back(8'h49);
        sb.push_back(8'h2D);
        sb.push_back(d);
        sb.push_back(8'h2D);
        sb.push_back(c);
        sb.push_back(8'h2D);
        sb.push_back(8'h23);
`ifdef SM_STATUS_TX_CRLF_EN
        sb.push_back(8'h0D);
        sb.push_back(8'h0A);
`endif
    endtask

    // One request: accept, scramble inputs mid byte 2, wait for tx_done,
    // optionally hold tx_start through DONE, then release the handshake
    task automatic send(input vec_t v, input bit hold);
        int t0;
        int n;
        int bad;
        push_frame(v.d, v.c);
        si_no    = v.si;
        color    = v.co;
        tx_start = 1'b1;
        tick();
        t0 = cyc;
        check("busy_on_accept", 32'(busy), 32'd1);
        check("tx_low_after_accept", 32'(tx), 32'd0);
        repeat (250) tick();
        si_no = ~v.si;
        color = ~v.co;
        n = 0;
        while (!tx_done && n < 3 * c_frame) begin
            tick();
            n++;
        end
        check("done_latency", 32'(cyc - t0), 32'(c_frame));
        check("frame_complete", 32'(sb.size()), 32'd0);
        if (hold) begin
            bad = 0;
            for (int i = 0; i < 500; i++) begin
                tick();
                if (tx !== 1'b1 || tx_done !== 1'b1 || busy !== 1'b1) bad++;
            end
            check("hold_no_restart", 32'(bad), 32'd0);
        end
        tx_start = 1'b0;
        tick();
        check("done_clear", 32'(tx_done), 32'd0);
        check("busy_clear", 32'(busy), 32'd0);
        repeat (20) tick();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int bad;
        vecs[0] = '{si: 2'd2, co: 2'd1, d: 8'h33, c: 8'h52};
        vecs[1] = '{si: 2'd0, co: 2'd0, d: 8'h31, c: 8'h4E};
        vecs[2] = '{si: 2'd0, co: 2'd2, d: 8'h31, c: 8'h47};
        vecs[3] = '{si: 2'd0, co: 2'd3, d: 8'h31, c: 8'h42};
        vecs[4] = '{si: 2'd3, co: 2'd2, d: 8'h34, c: 8'h47};
        vecs[5] = '{si: 2'd1, co: 2'd3, d: 8'h32, c: 8'h42};

        rst      = 1'b1;
        tx_start = 1'b0;
        si_no    = 2'd0;
        color    = 2'd0;
        repeat (2) tick();
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(tx_done), 32'd0);
        rst = 1'b0;
        tick();
        mon_en = 1'b1;

        for (int k = 0; k < 6; k++) begin
            send(vecs[k], k == 0);
        end

        // Reset during byte 4, data bit 3, with tx_start still high
        mon_en   = 1'b0;
        si_no    = 2'd1;
        color    = 2'd0;
        tx_start = 1'b1;
        tick();
        repeat (444) tick();
        check("mid_frame_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(tx_done), 32'd0);
        tick();
        check("reset_beats_start", 32'(busy), 32'd0);
        rst      = 1'b0;
        tx_start = 1'b0;
        bad      = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx !== 1'b1 || tx_done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("idle_after_reset", 32'(bad), 32'd0);
        mon_en = 1'b1;
        send(vecs[5], 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sm_status_uart_tx.md
Name: sm_status_uart_tx

Overview:
- Serialises one status-identification message per request onto the UART line to the base station.
- Sits downstream of the status-update logic, which raises tx_start (level) and holds it until tx_done.
- On accept, latches si_no/color, builds a fixed ASCII frame and sends it 8N1, LSB first.
- Signals completion with a 4-phase tx_start/tx_done handshake, so each request is sent exactly once.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
CLKS_PER_BIT, CLK_FREQ/BAUD (434), clocks per serial bit; integer division, must be >= 2

Ports:
clk  input  1  50 MHz system clock
rst  input  1  synchronous active-high reset
tx_start  input  1  level request; accepted only in IDLE
si_no  input  2  status identification number 0..3
color  input  2  colour code: 0 none, 1 red, 2 green, 3 blue
tx  output  1  UART serial line, idle high
tx_done  output  1  high in DONE until tx_start is seen low
busy  output  1  high from accept until DONE is left

Behaviour:
- Reset (sampled on posedge clk while rst=1): tx=1, tx_done=0, busy=0, state=IDLE, all counters 0. Applies mid-frame: line returns high on the next edge, partial frame abandoned, no tx_done.
- States:
  - IDLE -> START: tx_start=1 sampled; latch si_no/color, byte_idx=0, busy=1.
  - START -> DATA: start bit, tx=0.
  - DATA -> STOP: 8 data bits, bit_idx 0..7, LSB first.
  - STOP: tx=1.
    - -> START if byte_idx < N-1 (byte_idx+1).
    - -> DONE after the last byte.
  - DONE: tx_done=1, busy=1, tx=1.
  - DONE -> IDLE: on the first edge where tx_start=0; tx_done and busy drop that edge.
- Bit timing:
  - Each bit period is exactly CLKS_PER_BIT cycles.
  - baud_cnt counts 0..CLKS_PER_BIT-1 and resets at every bit boundary.
  - tx is a registered output. Its first low cycle is the clock after the accepting edge.
- Bytes are back-to-back with no idle gap. Frame length = N*10*CLKS_PER_BIT cycles; N=8 by default, giving 34720 cycles at the default parameters.
- Message, N=8: 'S' 'I' '-' D '-' C '-' '#'.
  - D = ASCII '1'+si_no (0x31..0x34).
  - C from latched color: 0 'N' (0x4E), 1 'R' (0x52), 2 'G' (0x47), 3 'B' (0x42).
- si_no/color changes after accept have no effect on the frame in progress.
- tx_start held high through DONE does not restart transmission. A new request needs tx_start low, then high again after IDLE is re-entered.
- tx_start=1 and rst=1 on the same edge: reset wins, no accept.

Optional Feature:
- Macro SM_STATUS_TX_CRLF_EN.
- Defined: frame extends to N=10; bytes 0x0D, 0x0A are appended after '#' before DONE. Frame length becomes 10*10*CLKS_PER_BIT cycles.
- Undefined: N=8, frame ends at '#', no CR/LF logic present.

Test Plan:
- Use CLK_FREQ=1000, BAUD=100, so CLKS_PER_BIT=10.
- Basic frame: rst 2 cycles, then tx_start=1, si_no=2, color=1 -> tx decodes 0x53 0x49 0x2D 0x33 0x2D 0x52 0x2D 0x23; tx low on the first cycle after accept; tx_done rises 800 cycles after accept.
- Colour map: color=0/2/3 with si_no=0 -> byte 3 = 0x31; byte 5 = 0x4E / 0x47 / 0x42 respectively.
- Handshake: hold tx_start=1 for 500 cycles after tx_done -> tx stays 1, no second start bit, tx_done held; drop tx_start -> tx_done=0 and busy=0 next edge.
- Input stability: change si_no 3->0 and color 2->1 mid-byte-2 -> frame still carries 0x34 and 0x47.
- Reset mid-frame: assert rst during byte 4 data bit 3 -> tx=1, busy=0, tx_done=0 next edge; a new request then sends a complete frame.
- With SM_STATUS_TX_CRLF_EN: si_no=1, color=3 -> frame ends 0x23 0x0D 0x0A; tx_done rises at 1000 cycles.
